// File: rtl/xbus_dram_bridge_pkg.sv
// Shared definitions for the Xbus-to-SDRAM bridge slave.
// Holds the DRAM address window limit and the bridge FSM state encoding.
package xbus_dram_bridge_pkg;

    // First Xbus word address that is not backed by SDRAM.
    localparam logic [21:0] DRAM_LIMIT = 22'o17000000;

    // Bridge FSM states. The explicit encoding keeps the state value stable
    // for anyone probing the design.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } bridgeState_e;

endpackage

// File: rtl/xbus_dram_bridge.sv
// Xbus slave that maps the low Xbus address window onto the SDRAM controller.
// Each accepted request runs one SDRAM read or write. The slave then holds a
// 4-phase ack, with the read data, until the master drops req.
module xbus_dram_bridge
    import xbus_dram_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    input  logic        req,
    input  logic        write,
    output logic        ack,
    output logic        decode,
    output logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_in,
    output logic [31:0] sdram_data_out,
    output logic        sdram_req,
    input  logic        sdram_ready,
    output logic        sdram_write,
    input  logic        sdram_done
);

    bridgeState_e state_q;
    logic        ack_q;
    logic        sdramReq_q;
    logic        sdramWrite_q;
    logic [31:0] dataOut_q;
    logic [21:0] sdramAddr_q;
    logic [31:0] sdramDataOut_q;

    // The address decode is purely combinational, so the bus interface can mux
    // slaves without waiting a cycle. It does not depend on req or on the state.
    assign decode = (addr < DRAM_LIMIT);

    assign ack            = ack_q;
    assign sdram_req      = sdramReq_q;
    assign sdram_write    = sdramWrite_q;
    assign dataout        = dataOut_q;
    assign sdram_addr     = sdramAddr_q;
    assign sdram_data_out = sdramDataOut_q;

    // Transaction FSM with registered outputs. Address and data are captured
    // once, on the accept edge, so later bus changes cannot disturb the
    // transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ack_q          <= 1'b0;
            sdramReq_q     <= 1'b0;
            sdramWrite_q   <= 1'b0;
            dataOut_q      <= 32'd0;
            sdramAddr_q    <= 22'd0;
            sdramDataOut_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && decode) begin
                        sdramAddr_q    <= addr;
                        sdramDataOut_q <= datain;
                        sdramReq_q     <= 1'b1;
                        sdramWrite_q   <= write;
                        state_q        <= write ? WR : RD;
                    end
                end
                RD: begin
                    if (sdram_ready) begin
                        dataOut_q  <= sdram_data_in;
                        sdramReq_q <= 1'b0;
                        ack_q      <= 1'b1;
                        state_q    <= ACK;
                    end
                end
                WR: begin
                    if (sdram_done) begin
                        sdramReq_q   <= 1'b0;
                        sdramWrite_q <= 1'b0;
                        ack_q        <= 1'b1;
                        state_q      <= ACK;
                    end
                end
                ACK: begin
                    // Only leaving ACK returns to IDLE. That guarantees
                    // sdram_req stays low for at least one cycle between
                    // transactions.
                    if (!req) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_dram_bridge.sv
// Directed testbench for xbus_dram_bridge.
// The bench drives the Xbus master and the SDRAM controller by hand.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_xbus_dram_bridge;
    import xbus_dram_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        req;
    logic        write;
    logic        ack;
    logic        decode;
    logic [21:0] sdram_addr;
    logic [31:0] sdram_data_in;
    logic [31:0] sdram_data_out;
    logic        sdram_req;
    logic        sdram_ready;
    logic        sdram_write;
    logic        sdram_done;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] lastRead;
    logic        sawActivity;

    always #5 clk = ~clk;

    xbus_dram_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .datain         (datain),
        .dataout        (dataout),
        .req            (req),
        .write          (write),
        .ack            (ack),
        .decode         (decode),
        .sdram_addr     (sdram_addr),
        .sdram_data_in  (sdram_data_in),
        .sdram_data_out (sdram_data_out),
        .sdram_req      (sdram_req),
        .sdram_ready    (sdram_ready),
        .sdram_write    (sdram_write),
        .sdram_done     (sdram_done)
    );

    // Compare one observed value with its expected value and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Run one full transfer.
    // The response is seen at the delay-th edge after the accept edge.
    // If noise is set, the SDRAM signal that the current state should ignore
    // is held high while the bench waits for the response.
    task automatic applyStimulus(input string tag, input logic [21:0] a, input logic w,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int delay, input logic noise);
        addr   = a;
        datain = wd;
        write  = w;
        req    = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, ".sdramReqRise"}, 32'(sdram_req), 32'd1);
        checkOutput({tag, ".sdramWrite"}, 32'(sdram_write), 32'(w));
        checkOutput({tag, ".sdramAddr"}, 32'(sdram_addr), 32'(a));
        if (w) checkOutput({tag, ".sdramDataOut"}, sdram_data_out, wd);
        addr   = ~a;
        datain = ~wd;
        write  = ~w;
        if (noise) begin
            if (w) sdram_ready = 1'b1;
            else   sdram_done  = 1'b1;
        end
        for (int i = 1; i < delay; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".sdramReqHeld"}, 32'(sdram_req), 32'd1);
            checkOutput({tag, ".ackEarly"}, 32'(ack), 32'd0);
        end
        sdram_ready = 1'b0;
        sdram_done  = 1'b0;
        if (w) begin
            sdram_done = 1'b1;
        end else begin
            sdram_ready   = 1'b1;
            sdram_data_in = rd;
        end
        @(posedge clk); #1;
        sdram_ready   = 1'b0;
        sdram_done    = 1'b0;
        sdram_data_in = 32'h0BAD0BAD;
        if (!w) lastRead = rd;
        checkOutput({tag, ".ackRise"}, 32'(ack), 32'd1);
        checkOutput({tag, ".sdramReqFall"}, 32'(sdram_req), 32'd0);
        checkOutput({tag, ".sdramWriteFall"}, 32'(sdram_write), 32'd0);
        checkOutput({tag, ".dataout"}, dataout, lastRead);
        @(posedge clk); #1;
        checkOutput({tag, ".ackHeld"}, 32'(ack), 32'd1);
        req = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, ".ackFall"}, 32'(ack), 32'd0);
        checkOutput({tag, ".sdramReqIdle"}, 32'(sdram_req), 32'd0);
        checkOutput({tag, ".dataoutKept"}, dataout, lastRead);
    endtask

    // Stop a runaway simulation, so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        addr          = 22'd0;
        datain        = 32'd0;
        req           = 1'b0;
        write         = 1'b0;
        sdram_data_in = 32'd0;
        sdram_ready   = 1'b0;
        sdram_done    = 1'b0;
        lastRead      = 32'd0;
        sawActivity   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        checkOutput("reset.ack", 32'(ack), 32'd0);
        checkOutput("reset.sdramReq", 32'(sdram_req), 32'd0);
        checkOutput("reset.sdramWrite", 32'(sdram_write), 32'd0);
        checkOutput("reset.dataout", dataout, 32'd0);
        checkOutput("reset.sdramAddr", 32'(sdram_addr), 32'd0);
        checkOutput("reset.sdramDataOut", sdram_data_out, 32'd0);

        addr = 22'o16777777; #1;
        checkOutput("decode.top", 32'(decode), 32'd1);
        addr = 22'o17000000; #1;
        checkOutput("decode.limit", 32'(decode), 32'd0);
        addr = 22'o00000000; #1;
        checkOutput("decode.zero", 32'(decode), 32'd1);

        applyStimulus("read1", 22'o00001234, 1'b0, 32'd0, 32'hDEADBEEF, 3, 1'b0);
        applyStimulus("write1", 22'o16777777, 1'b1, 32'h12345678, 32'd0, 2, 1'b0);

        addr  = 22'o17000000;
        write = 1'b0;
        req   = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (sdram_req || ack) sawActivity = 1'b1;
        end
        checkOutput("outOfRange.decode", 32'(decode), 32'd0);
        checkOutput("outOfRange.activity", 32'(sawActivity), 32'd0);
        req = 1'b0;
        @(posedge clk); #1;

        addr  = 22'o00000100;
        write = 1'b0;
        req   = 1'b1;
        @(posedge clk); #1;
        checkOutput("midReset.inRead", 32'(sdram_req), 32'd1);
        reset = 1'b1;
        req   = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        lastRead = 32'd0;
        checkOutput("midReset.sdramReq", 32'(sdram_req), 32'd0);
        checkOutput("midReset.ack", 32'(ack), 32'd0);
        checkOutput("midReset.dataout", dataout, 32'd0);
        checkOutput("midReset.state", 32'(dut.state_q), 32'(IDLE));

        applyStimulus("readAfterReset", 22'o00000100, 1'b0, 32'd0, 32'hCAFEF00D, 2, 1'b0);
        applyStimulus("b2bRead1", 22'o00000010, 1'b0, 32'd0, 32'd1, 1, 1'b0);
        applyStimulus("b2bRead2", 22'o00000011, 1'b0, 32'd0, 32'd2, 1, 1'b0);
        applyStimulus("doneIgnored", 22'o00005555, 1'b0, 32'd0, 32'hA5A5A5A5, 6, 1'b1);
        applyStimulus("readyIgnored", 22'o00000777, 1'b1, 32'h0F0F0F0F, 32'd0, 4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/xbus_dram_bridge.md
Name: xbus_dram_bridge

Overview:
- Xbus slave that maps the low Xbus address range onto the external SDRAM controller.
- Sits inside the bus interface beside the disk, TV, I/O and unibus slaves.
- The bus arbiter drives addr/data/req/write from the CPU, or from the disk DMA master during slave cycles.
- Decodes its range, runs one SDRAM read or write per request, and returns a 4-phase ack with read data.

Parameters:
- DRAM_LIMIT, 22'o17000000: first address not owned; decode is addr < DRAM_LIMIT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  22  Xbus word address.
- datain  in  32  write data from current master.
- dataout  out  32  read data to master.
- req  in  1  request from master; held until ack, then dropped.
- write  in  1  1 = write, 0 = read; valid with req.
- ack  out  1  transfer complete; level held until req drops.
- decode  out  1  combinational: addr lies in DRAM range.
- sdram_addr  out  22  address to SDRAM controller.
- sdram_data_in  in  32  read data from SDRAM.
- sdram_data_out  out  32  write data to SDRAM.
- sdram_req  out  1  SDRAM operation request.
- sdram_ready  in  1  read data valid on sdram_data_in.
- sdram_write  out  1  SDRAM operation is a write.
- sdram_done  in  1  SDRAM write completed.

Behaviour:
- decode = (addr < DRAM_LIMIT). Combinational; independent of req and state.
- FSM states: IDLE, RD, WR, ACK. Reset (synchronous) forces IDLE, including mid-operation.
- Reset values: ack=0, sdram_req=0, sdram_write=0, dataout=0, sdram_addr=0, sdram_data_out=0.
- IDLE:
  - On an edge with req & decode, latch addr into sdram_addr and datain into sdram_data_out.
  - Then go to WR (write=1) or RD (write=0).
  - req with decode=0 is ignored: no SDRAM activity, no ack.
- RD:
  - sdram_req=1, sdram_write=0.
  - On an edge with sdram_ready=1: latch sdram_data_in into dataout, drop sdram_req, go to ACK.
  - sdram_done is ignored in RD.
- WR:
  - sdram_req=1, sdram_write=1.
  - On an edge with sdram_done=1: drop sdram_req and sdram_write, go to ACK.
  - sdram_ready is ignored in WR.
- ACK:
  - ack=1; dataout holds the read value.
  - Stays in ACK while req=1. On an edge with req=0, clear ack and go to IDLE.
- All outputs except decode are registered.
- Latency: req at edge k gives sdram_req high after k. SDRAM response seen at edge m gives ack high after m.
  - Minimum req-to-ack is 2 cycles. The arbiter times out after 63 cycles.
- sdram_req is guaranteed low for at least one cycle between consecutive transactions.
- addr/datain/write changes after the IDLE latch edge have no effect on the transaction in flight.
- dataout keeps its last read value after writes and across idle periods. Only reset or a new read changes it.
- Back-to-back: after the ack falls, a new req is accepted on the first edge in IDLE.
- Address wrap: none; 22-bit addresses pass through unchanged.

Decomposition:
- Shared package: DRAM_LIMIT constant and the 2-bit state encoding (IDLE=0, RD=1, WR=2, ACK=3).
- Single flat module; no sub-module warranted.

Test Plan:
- Read, addr=22'o00001234, SDRAM model ready 3 cycles after sdram_req with data 32'hDEADBEEF:
  - sdram_addr=22'o1234, sdram_write=0, sdram_req high 3 cycles.
  - ack rises next edge with dataout=DEADBEEF; ack falls one edge after req drops.
- Write, addr=22'o16777777 (top of range), datain=32'h12345678, done after 2 cycles:
  - sdram_write=1, sdram_data_out=12345678, sdram_addr=22'o16777777.
  - ack asserted; dataout unchanged.
- addr=22'o17000000 with req=1 for 70 cycles:
  - decode=0, sdram_req never rises, ack stays 0.
- Reset pulsed while in RD:
  - Next cycle sdram_req=0, ack=0, dataout=0, state IDLE.
  - A subsequent read completes normally.
- Two back-to-back reads (data 1, then 2) with immediate ready:
  - sdram_req low at least one cycle between them; acks show dataout 1 then 2.
- Read with sdram_done pulsed but no ready for 5 cycles, then ready:
  - ack only after ready; the done pulse is ignored.
